serv_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares a single memory/peripheral port between the SERV instruction bus (ibus) and data bus (dbus). It sits between `serv_rf_top` and the shared memory or interconnect. It serialises accesses, routes data and acknowledge back to the owning requester, and optionally recovers from a slave that never acknowledges.

---
 rtl/serv_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_serv_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one slave port between the SERV ibus and dbus.
// The arbiter alternates between the two masters on a tie, routes data and
// acknowledge back to the owner and inserts one recovery cycle after each
// completion.
// Optional feature: define SERV_BUS_ARBITER_TIMEOUT_EN to force completion
// with ERR_RDT when the slave does not ack within TIMEOUT_CYCLES cycles.
module serv_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDT        = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_m_adr,
    output logic [31:0] o_m_dat,
    output logic [3:0]  o_m_sel,
    output logic        o_m_we,
    output logic        o_m_cyc,
    input  logic [31:0] i_m_rdt,
    input  logic        i_m_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD, StRec} state_e;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic        last_d_q;  // 1 when dbus owned the most recent completed transaction
    logic        gnt_i;
    logic        gnt_d;
    logic        sel_cyc;
    logic        tmo;
    logic        done;
    logic [31:0] rdt;

    assign gnt_i = (state_q == StGntI);
    assign gnt_d = (state_q == StGntD);

    // Request line of the current owner; zero when nobody owns the bus.
    always_comb begin
        sel_cyc = 1'b0;
        if (gnt_i) begin
            sel_cyc = i_ibus_cyc;
        end else if (gnt_d) begin
            sel_cyc = i_dbus_cyc;
        end
    end

`ifdef SERV_BUS_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_q;

    assign tmo = sel_cyc && !i_m_ack && (cnt_q == TimeoutVal);

    // Wait counter: zero outside a grant, so it is already clear on entry.
    always_ff @(posedge clk) begin
        if (rst || !(gnt_i || gnt_d)) begin
            cnt_q <= 16'd0;
        end else if (!i_m_ack) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TimeoutVal;
    assign tmo            = 1'b0;
`endif

    // A slave ack beats a coincident timeout; an abort (cyc low) discards both.
    assign done = sel_cyc && (i_m_ack || tmo);
    assign rdt  = i_m_ack ? i_m_rdt : ERR_RDT;

    // Arbitration FSM and tie-break history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_ibus_cyc && i_dbus_cyc) begin
                        state_q <= last_d_q ? StGntI : StGntD;
                    end else if (i_ibus_cyc) begin
                        state_q <= StGntI;
                    end else if (i_dbus_cyc) begin
                        state_q <= StGntD;
                    end
                end
                StGntI, StGntD: begin
                    if (!sel_cyc) begin
                        state_q <= StIdle;
                    end else if (done) begin
                        state_q  <= StRec;
                        last_d_q <= gnt_d;
                    end
                end
                StRec:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Slave-side mux and requester responses, all qualified by the owner.
    always_comb begin
        o_grant    = {gnt_d, gnt_i};
        o_m_adr    = 32'd0;
        o_m_dat    = 32'd0;
        o_m_sel    = 4'h0;
        o_m_we     = 1'b0;
        o_m_cyc    = 1'b0;
        o_ibus_ack = 1'b0;
        o_ibus_rdt = 32'd0;
        o_dbus_ack = 1'b0;
        o_dbus_rdt = 32'd0;
        o_timeout  = tmo;
        if (gnt_i) begin
            o_m_adr    = i_ibus_adr;
            o_m_sel    = 4'hF;
            o_m_cyc    = i_ibus_cyc && !tmo;
            o_ibus_ack = done;
            o_ibus_rdt = done ? rdt : 32'd0;
        end else if (gnt_d) begin
            o_m_adr    = i_dbus_adr;
            o_m_dat    = i_dbus_dat;
            o_m_sel    = i_dbus_sel;
            o_m_we     = i_dbus_we;
            o_m_cyc    = i_dbus_cyc && !tmo;
            o_dbus_ack = done;
            o_dbus_rdt = done ? rdt : 32'd0;
        end
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
// Builds with or without SERV_BUS_ARBITER_TIMEOUT_EN.
module tb_serv_bus_arbiter;

    localparam int unsigned To  = 8;
    localparam logic [31:0] Err = 32'hDEAD_BEEF;
`ifdef SERV_BUS_ARBITER_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_adr, ibus_rdt;
    logic        ibus_cyc, ibus_ack;
    logic [31:0] dbus_adr, dbus_dat, dbus_rdt;
    logic [3:0]  dbus_sel;
    logic        dbus_we, dbus_cyc, dbus_ack;
    logic [31:0] m_adr, m_dat, m_rdt;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_ack;
    logic [1:0]  grant;
    logic        timeout;

    always #5 clk = ~clk;

    serv_bus_arbiter #(
        .TIMEOUT_CYCLES(To),
        .ERR_RDT       (Err)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_ibus_adr(ibus_adr),
        .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt),
        .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr),
        .i_dbus_dat(dbus_dat),
        .i_dbus_sel(dbus_sel),
        .i_dbus_we (dbus_we),
        .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt),
        .o_dbus_ack(dbus_ack),
        .o_m_adr   (m_adr),
        .o_m_dat   (m_dat),
        .o_m_sel   (m_sel),
        .o_m_we    (m_we),
        .o_m_cyc   (m_cyc),
        .i_m_rdt   (m_rdt),
        .i_m_ack   (m_ack),
        .o_grant   (grant),
        .o_timeout (timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 none, 0 ibus, 1 dbus), whether the
    // one-cycle cool-down after a completion is pending, who completed last,
    // and how many cycles the current owner has waited.
    int owner      = -1;
    bit cool       = 1'b0;
    int last_owner = 0;
    int waited     = 0;

    logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
    logic [3:0]  e_sel;
    logic [1:0]  e_grant;
    logic        e_we, e_mcyc, e_iack, e_dack, e_tmo, e_done, e_cyc;

    // Compute expected outputs for the current inputs and compare.
    task automatic sample();
        logic [31:0] data;
        @(negedge clk);
        e_grant = 2'b00; e_mcyc = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
        e_iack = 1'b0; e_irdt = '0; e_dack = 1'b0; e_drdt = '0; e_tmo = 1'b0;
        e_done = 1'b0; e_cyc = 1'b0;
        if (owner >= 0) begin
            e_cyc   = (owner == 0) ? ibus_cyc : dbus_cyc;
            e_tmo   = ToEn && e_cyc && !m_ack && (waited == int'(To));
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
            e_mcyc  = e_cyc && !e_tmo;
            if (owner == 0) begin
                e_adr = ibus_adr;
                e_sel = 4'hF;
            end else begin
                e_adr = dbus_adr;
                e_dat = dbus_dat;
                e_sel = dbus_sel;
                e_we  = dbus_we;
            end
            e_done = e_cyc && (m_ack || e_tmo);
            data   = m_ack ? m_rdt : Err;
            if (e_done && owner == 0) begin
                e_iack = 1'b1;
                e_irdt = data;
            end
            if (e_done && owner == 1) begin
                e_dack = 1'b1;
                e_drdt = data;
            end
        end
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("m_cyc", 32'(m_cyc), 32'(e_mcyc));
        check_eq("m_adr", m_adr, e_adr);
        check_eq("m_dat", m_dat, e_dat);
        check_eq("m_sel", 32'(m_sel), 32'(e_sel));
        check_eq("m_we", 32'(m_we), 32'(e_we));
        check_eq("ibus_ack", 32'(ibus_ack), 32'(e_iack));
        check_eq("ibus_rdt", ibus_rdt, e_irdt);
        check_eq("dbus_ack", 32'(dbus_ack), 32'(e_dack));
        check_eq("dbus_rdt", dbus_rdt, e_drdt);
        check_eq("timeout", 32'(timeout), 32'(e_tmo));
    endtask

    // Move the model to the next cycle and step to just after the clock edge.
    task automatic advance();
        if (rst) begin
            owner = -1; cool = 1'b0; last_owner = 0; waited = 0;
        end else if (owner >= 0) begin
            if (!e_cyc) begin
                owner = -1;
            end else if (e_done) begin
                last_owner = owner;
                owner      = -1;
                cool       = 1'b1;
            end else begin
                waited++;
            end
        end else if (cool) begin
            cool = 1'b0;
        end else if (ibus_cyc && dbus_cyc) begin
            owner  = (last_owner == 0) ? 1 : 0;
            waited = 0;
        end else if (ibus_cyc) begin
            owner  = 0;
            waited = 0;
        end else if (dbus_cyc) begin
            owner  = 1;
            waited = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic reset_tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    bit quiet;

    initial begin
        rst = 1'b1; ibus_adr = '0; ibus_cyc = 1'b0; dbus_adr = '0; dbus_dat = '0;
        dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0; m_rdt = '0; m_ack = 1'b0;
        @(posedge clk);
        #1;
        // Reset state: all outputs zero.
        reset_tick();

        // Single fetch, slave acks one cycle after o_m_cyc.
        ibus_cyc = 1'b1; ibus_adr = 32'h10;
        sample(); check_eq("fetch_idle_grant", 32'(grant), 32'd0); advance();
        sample(); check_eq("fetch_adr", m_adr, 32'h10); check_eq("fetch_grant", 32'(grant), 32'd1);
        advance();
        m_ack = 1'b1; m_rdt = 32'h13;
        sample(); check_eq("fetch_ack", 32'(ibus_ack), 32'd1);
        check_eq("fetch_rdt", ibus_rdt, 32'h13); advance();
        ibus_cyc = 1'b0; m_ack = 1'b0;
        sample(); check_eq("fetch_rec_grant", 32'(grant), 32'd0); advance();
        tick();

        // Byte write, acked in the first granted cycle.
        dbus_cyc = 1'b1; dbus_adr = 32'h104; dbus_dat = 32'hAB; dbus_sel = 4'b0001; dbus_we = 1'b1;
        tick();
        m_ack = 1'b1; m_rdt = 32'h5555_AAAA;
        sample(); check_eq("wr_we", 32'(m_we), 32'd1); check_eq("wr_sel", 32'(m_sel), 32'd1);
        check_eq("wr_ack", 32'(dbus_ack), 32'd1); advance();
        dbus_cyc = 1'b0; dbus_we = 1'b0; m_ack = 1'b0;
        tick(); tick();

        // Ties from reset alternate dbus, ibus, dbus.
        reset_tick();
        ibus_cyc = 1'b1; ibus_adr = 32'h200; dbus_cyc = 1'b1; dbus_adr = 32'h300; dbus_sel = 4'hF;
        tick();
        m_ack = 1'b1;
        sample(); check_eq("tie1_grant", 32'(grant), 32'd2); advance();
        dbus_cyc = 1'b0; m_ack = 1'b0;
        tick(); tick();
        m_ack = 1'b1;
        sample(); check_eq("tie2_grant", 32'(grant), 32'd1); advance();
        ibus_cyc = 1'b0; m_ack = 1'b0;
        tick();
        ibus_cyc = 1'b1; dbus_cyc = 1'b1;
        tick();
        m_ack = 1'b1;
        sample(); check_eq("tie3_grant", 32'(grant), 32'd2); advance();
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; m_ack = 1'b0;
        tick(); tick();

        // Reset while dbus is granted and the slave stalls.
        dbus_cyc = 1'b1;
        tick(); tick();
        reset_tick();
        m_ack = 1'b1;
        sample(); check_eq("rst_mcyc", 32'(m_cyc), 32'd0); check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_dack", 32'(dbus_ack), 32'd0); advance();
        dbus_cyc = 1'b0; m_ack = 1'b0;
        tick(); tick(); tick();

        // Abort: ibus drops cyc in its grant, a coincident slave ack is discarded.
        ibus_cyc = 1'b1;
        tick(); tick();
        ibus_cyc = 1'b0; m_ack = 1'b1;
        sample(); check_eq("abort_mcyc", 32'(m_cyc), 32'd0); check_eq("abort_ack", 32'(ibus_ack), 32'd0);
        advance();
        m_ack = 1'b0;
        sample(); check_eq("abort_idle", 32'(grant), 32'd0); advance();

        // Slave never acks.
        reset_tick();
        dbus_cyc = 1'b1;
        tick();
        for (int k = 0; k < int'(To); k++) begin
            if (k == 2) ibus_cyc = 1'b1;
            sample(); check_eq("stall_tmo", 32'(timeout), 32'd0); check_eq("stall_dack", 32'(dbus_ack), 32'd0);
            advance();
        end
        sample();
        if (ToEn) begin
            check_eq("tmo_pulse", 32'(timeout), 32'd1);
            check_eq("tmo_rdt", dbus_rdt, 32'hDEADBEEF);
            check_eq("tmo_mcyc", 32'(m_cyc), 32'd0);
        end else begin
            check_eq("hold_grant", 32'(grant), 32'd2);
            check_eq("hold_dack", 32'(dbus_ack), 32'd0);
        end
        advance();
        dbus_cyc = 1'b0;
        tick(); tick();
        m_ack = 1'b1; m_rdt = 32'h1234_5678;
        sample(); check_eq("after_stall_iack", 32'(ibus_ack), 32'd1); advance();
        ibus_cyc = 1'b0; m_ack = 1'b0;
        tick(); tick();

        // Randomized traffic with occasional aborts, resets and silent-slave stretches.
        quiet = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) quiet = ($urandom_range(0, 3) == 0);
            if (ibus_cyc) begin
                if (e_iack || $urandom_range(0, 19) == 0) ibus_cyc = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                ibus_cyc = 1'b1;
                ibus_adr = $urandom;
            end
            if (dbus_cyc) begin
                if (e_dack || $urandom_range(0, 19) == 0) dbus_cyc = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                dbus_cyc = 1'b1;
                dbus_adr = $urandom;
                dbus_dat = $urandom;
                dbus_sel = 4'($urandom_range(0, 15));
                dbus_we  = 1'($urandom_range(0, 1));
            end
            m_ack = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
            m_rdt = $urandom;
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
